pusher_feed_sched: RTL

- Sequencer that feeds DIM Pusher lanes of the matrix multiplier from a 1-cycle-latency operand buffer.
- On start, it reads DIM row/column words (one per cycle) and presents word r to lane r for exactly one cycle. Issue is skewed one cycle per lane, which gives the diagonal wavefront the PE array expects.
- It tracks each lane's element-streaming window and signals completion.
- It sits between the operand buffer and the DIM Pusher instances, under the top-level matrix controller.

---
 rtl/pusher_feed_sched_pkg.sv | 39 +++
 rtl/pusher_feed_sched_if.sv | 29 ++
 rtl/pusher_feed_sched_lane_window.sv | 31 +++
 rtl/pusher_feed_sched.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pusher_feed_sched_pkg.sv
// pusher_sched_pkg: shared types and timing constants for the Pusher feed sequencer.
package pusher_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Cycles from start acceptance (T) to the first lane-data issue is ISSUE_LAT+1.
  localparam int ISSUE_LAT = 2;
  // Lane r's valid window opens at T+VALID_OFS+1+r.
  localparam int VALID_OFS = 3;

  // Counter must hold 0 .. 2*DIM+3.
  function automatic int cnt_width(input int dim);
    int w;
    w = $clog2(2 * dim + 3);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Buffer address width, never narrower than one bit.
  function automatic int addr_width(input int dim);
    int w;
    w = $clog2(dim);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/pusher_feed_sched_if.sv
// pusher_feed_sched_if: buffer read port, lane outputs and control handshake.
// abort_i exists only when PUSH_SCHED_ABORT_EN is defined.
interface pusher_feed_sched_if #(
  parameter int DIM       = 4,
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_W    = 2
);
  logic                     start_i;
  logic                     rd_en_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic [BUS_WIDTH-1:0]     rd_data_i;
  logic [DIM*BUS_WIDTH-1:0] lane_data_o;
  logic [DIM-1:0]           lane_valid_o;
  logic                     busy_o;
  logic                     done_o;
`ifdef PUSH_SCHED_ABORT_EN
  logic                     abort_i;

  modport master (output start_i, rd_data_i, abort_i,
                  input  rd_en_o, rd_addr_o, lane_data_o, lane_valid_o, busy_o, done_o);
  modport slave  (input  start_i, rd_data_i, abort_i,
                  output rd_en_o, rd_addr_o, lane_data_o, lane_valid_o, busy_o, done_o);
`else
  modport master (output start_i, rd_data_i,
                  input  rd_en_o, rd_addr_o, lane_data_o, lane_valid_o, busy_o, done_o);
  modport slave  (input  start_i, rd_data_i,
                  output rd_en_o, rd_addr_o, lane_data_o, lane_valid_o, busy_o, done_o);
`endif
endinterface

// File: rtl/pusher_feed_sched_lane_window.sv
// sched_lane_window: registered valid window for one Pusher lane. The input is
// the count the sequencer is about to enter, so the output lines up with it.
module sched_lane_window
  import pusher_sched_pkg::*;
#(
  parameter int DIM  = 4,
  parameter int LANE = 0,
  parameter int CW   = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [CW-1:0] cnt_i,
  output logic          valid_o
);
  localparam logic [CW-1:0] WIN_FIRST = CW'(VALID_OFS + 1 + LANE);
  localparam logic [CW-1:0] WIN_LAST  = CW'(VALID_OFS + LANE + DIM);

  logic valid_r;

  // Window register: high while the upcoming count lies inside this lane's window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= (cnt_i >= WIN_FIRST) && (cnt_i <= WIN_LAST);
    end
  end

  assign valid_o = valid_r;

endmodule

// File: rtl/pusher_feed_sched.sv
// pusher_feed_sched: reads DIM words from the operand buffer and issues word r
// to lane r for one cycle, skewed one cycle per lane, then tracks each lane's
// streaming window and pulses done_o. Optional abort: PUSH_SCHED_ABORT_EN.
module pusher_feed_sched
  import pusher_sched_pkg::*;
#(
  parameter int DIM        = 4,
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = addr_width(DIM)
) (
  input logic                clk_i,
  input logic                rst_ni,
  pusher_feed_sched_if.slave bus
);
  localparam int CW = cnt_width(DIM);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(DIM);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(2 * DIM + 2);
  localparam logic [CW-1:0] DONE_CNT   = CW'(2 * DIM + 3);

  if (BUS_WIDTH != DIM * DATA_WIDTH) begin : g_width_chk
    $error("BUS_WIDTH must equal DIM*DATA_WIDTH");
  end

  sched_state_e             state_r;
  logic [CW-1:0]            cnt_r;
  logic [CW-1:0]            cnt_nxt_s;
  logic                     abort_s;
  logic                     rd_en_r;
  logic [ADDR_W-1:0]        rd_addr_r;
  logic [DIM*BUS_WIDTH-1:0] lane_data_r;
  logic [DIM-1:0]           lane_valid_s;
  logic                     busy_r;
  logic                     done_r;

`ifdef PUSH_SCHED_ABORT_EN
  assign abort_s = bus.abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // Next count: the cycle index relative to start acceptance that we enter next.
  // 0 means idle; the done cycle (DONE_CNT) is idle too and may accept a start.
  always_comb begin
    cnt_nxt_s = '0;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          cnt_nxt_s = CNT_ONE;
        end else begin
          cnt_nxt_s = '0;
        end
      end
      FETCH, DRAIN: begin
        if (abort_s) begin
          cnt_nxt_s = '0;
        end else if (cnt_r == BUSY_LAST) begin
          cnt_nxt_s = DONE_CNT;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: cnt_nxt_s = '0;
    endcase
  end

  // Sequencer FSM: state, counter and every registered output decoded from the next count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      lane_data_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if ((cnt_nxt_s == '0) || (cnt_nxt_s == DONE_CNT)) begin
        state_r <= IDLE;
      end else if (cnt_nxt_s <= FETCH_LAST) begin
        state_r <= FETCH;
      end else begin
        state_r <= DRAIN;
      end
      if ((cnt_nxt_s >= CNT_ONE) && (cnt_nxt_s <= FETCH_LAST)) begin
        rd_en_r   <= 1'b1;
        rd_addr_r <= ADDR_W'(cnt_nxt_s - CNT_ONE);
      end else begin
        rd_en_r   <= 1'b0;
        rd_addr_r <= '0;
      end
      busy_r <= (cnt_nxt_s >= CNT_ONE) && (cnt_nxt_s <= BUSY_LAST);
      done_r <= (cnt_nxt_s == DONE_CNT);
      // Word r arrives one cycle after its read and sits on lane r for one cycle.
      for (int r = 0; r < DIM; r++) begin
        if (cnt_nxt_s == CW'(ISSUE_LAT + 1 + r)) begin
          lane_data_r[r*BUS_WIDTH +: BUS_WIDTH] <= bus.rd_data_i;
        end else begin
          lane_data_r[r*BUS_WIDTH +: BUS_WIDTH] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    sched_lane_window #(
      .DIM  (DIM),
      .LANE (g),
      .CW   (CW)
    ) u_win (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .cnt_i   (cnt_nxt_s),
      .valid_o (lane_valid_s[g])
    );
  end

  assign bus.rd_en_o      = rd_en_r;
  assign bus.rd_addr_o    = rd_addr_r;
  assign bus.lane_data_o  = lane_data_r;
  assign bus.lane_valid_o = lane_valid_s;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;

endmodule
